bus_arbiter: RTL
================

# bus_arbiter

Round-robin arbiter that shares one single-port `ram` instance among `NUM_CLIENTS` requesters using the rq/ack handshake. It sits between the clients and the RAM and forwards one client's request fields at a time. It inserts a mandatory idle cycle on the RAM `rq` line between transactions. That gap is required because the RAM raises `ack` on the second consecutive cycle of `rq`.

## Interface
- `NUM_CLIENTS`, default 4: number of requesters, 2..16.
- `DATA_WIDTH`, default 8: RAM data width.
- `ADDR_WIDTH`, default 4: RAM address width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rq_i`  in  NUM_CLIENTS  per-client request.
- `wr_ni_i`  in  NUM_CLIENTS  per-client operation select; 1 = read, 0 = write.
- `address_i`  in  NUM_CLIENTS*ADDR_WIDTH  client k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- `dataW_i`  in  NUM_CLIENTS*DATA_WIDTH  client k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- `ack_o`  out  NUM_CLIENTS  per-client acknowledge; one-hot or zero.
- `dataR_o`  out  DATA_WIDTH  read data, broadcast to all clients; valid only alongside that client's `ack_o`.
- `mem_rq`  out  1  RAM request.
- `mem_wr_ni`  out  1  RAM operation select.
- `mem_address`  out  ADDR_WIDTH  RAM address.
- `mem_dataW`  out  DATA_WIDTH  RAM write data.
- `mem_ack`  in  1  RAM acknowledge.
- `mem_dataR`  in  DATA_WIDTH  RAM read data.

## Operation
- **FSM states:** IDLE, BUSY, GAP. Registers: `state`, `grant` (index), `ptr` (round-robin start index).
- **IDLE:** when any `rq_i` bit is high, load `grant` with the first requester at or after `ptr`, searching upward modulo `NUM_CLIENTS`, and go to BUSY. Otherwise stay in IDLE.
- **BUSY, RAM-side outputs:**
  - `mem_rq = rq_i[grant]`.
  - `mem_wr_ni`, `mem_address` and `mem_dataW` are muxed from client `grant`.
- **BUSY, acknowledge:** `ack_o[grant] = mem_ack`, passed through combinationally.
- **BUSY, completion:** on `mem_ack`, set `ptr <= (grant+1) mod NUM_CLIENTS` and go to GAP.
- **BUSY, abort:** if `rq_i[grant]` falls before `mem_ack`, go to GAP. No ack is given and `ptr` is unchanged.
- **GAP:** `mem_rq = 0` for exactly one cycle, which clears the RAM's `rq_d`. GAP then behaves as IDLE: it picks the next requester using `ptr` and enters BUSY directly, or goes to IDLE if nothing is requesting.
- **Outputs outside BUSY:** `mem_rq = 0` and `ack_o = 0`.
  - `mem_wr_ni` is held at 1 (read), so no write occurs.
  - `mem_address` and `mem_dataW` are don't-care and are driven from client `grant`.
- **Read data:** `dataR_o = mem_dataR` at all times.
- **Client rules:**
  - Hold `rq`, `wr_ni`, `address` and `dataW` stable until `ack`.
  - `rq` still high in the cycle after `ack` counts as a new request.
- **Reset values:** `state` = IDLE, `grant` = 0, `ptr` = 0. All outputs are 0 except `mem_wr_ni` = 1 and `dataR_o`, which follows `mem_dataR`.
- **Reset mid-transaction:** `mem_rq` drops immediately. A write already clocked into the RAM stays committed. No ack is issued.

## Timing
- **Uncontended read or write** (client raises `rq` in cycle 0, after the edge):
  - edge 1: BUSY; `mem_rq` high in cycle 1.
  - edge 2: RAM samples `rq`; `mem_ack` and `ack_o` high in cycle 2, with read data valid in cycle 2.
  - edge 3: GAP.
- **Back-to-back clients:** when another client is waiting, its transaction enters BUSY at edge 4. Sustained throughput is one transaction per 3 cycles.
- **Register boundaries:** `grant` and `state` are registered. `mem_*` outputs and `ack_o` are combinational from registers and client inputs; there is no combinational path from `mem_ack` to `mem_rq`.
- **Arbitration timing:** requests are sampled only at IDLE/GAP exit edges. A request arriving during BUSY waits.
- **Starvation bound:** with all clients requesting, each is served within `NUM_CLIENTS` transactions.

## Structure
- **Package `bus_arb_pkg`:**
  - state enum {IDLE, BUSY, GAP};
  - `clog2` function for the `grant`/`ptr` width.
- **Sub-module `rr_picker`:** combinational. Inputs are the request vector and `ptr`; outputs are `found` and the index of the first set bit at or after `ptr` (modulo `NUM_CLIENTS`). It is reusable for other shared resources.
- **Top level** holds the FSM, the registers and the field muxes. It instantiates `rr_picker` once.

## Test plan
- **Single read:** after preloading `mem[3]` = 0xA5, client 0 reads address 3. Require `mem_rq` high in cycles 1-2, `ack_o` = 4'b0001 in cycle 2 only, and `dataR_o` = 0xA5 in cycle 2.
- **Write then read:** client 2 writes 0x3C to address 7, then reads address 7. Require `ack_o[2]` once per transaction, the read returning 0x3C, and `mem_rq` low for exactly one cycle between the transactions.
- **All four clients assert `rq` simultaneously from reset:** grants must occur in order 0,1,2,3, each `ack_o` must be one-hot, and `mem_rq` must never stay high across a grant change.
- **Fairness:** clients 1 and 3 hold `rq` continuously for 6 transactions. Grants must alternate 1,3,1,3,1,3 and client 0 must never be acked.
- **Abort:** client 1 drops `rq` in cycle 1 of BUSY. Require no `ack_o`, a GAP cycle, `ptr` unchanged, and a following request from client 1 served next.
- **Async reset in cycle 1 of a write:** `mem_rq` and `ack_o` must go to 0 without waiting for an edge, and the FSM must restart in IDLE with `ptr` = 0.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the round-robin RAM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package bus_arb_pkg;

    // Arbiter FSM: waiting for a request, serving a grant, forced RAM idle cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } arb_state_e;

    // Ceiling log2, with a minimum of 1 so that index vectors never collapse to zero width.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v * 2;
            r = r + 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: index of the first set request bit at or after ptr_i, wrapping modulo N.
// Latency: purely combinational.
// Backpressure: none; found_o low when no bit of req_i is set.
module rr_picker
    import bus_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    logic             found_hi;
    logic [IDX_W-1:0] idx_hi;
    logic             found_lo;
    logic [IDX_W-1:0] idx_lo;

    // Two scans: the lowest request at or above ptr wins; otherwise wrap to the lowest request overall.
    always_comb begin
        found_hi = 1'b0;
        idx_hi   = '0;
        found_lo = 1'b0;
        idx_lo   = '0;
        for (int k = 0; k < N; k++) begin
            if (req_i[k] && !found_hi && (IDX_W'(k) >= ptr_i)) begin
                found_hi = 1'b1;
                idx_hi   = IDX_W'(k);
            end
            if (req_i[k] && !found_lo) begin
                found_lo = 1'b1;
                idx_lo   = IDX_W'(k);
            end
        end
        found_o = found_hi | found_lo;
        idx_o   = found_hi ? idx_hi : idx_lo;
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one single-port RAM (rq/ack handshake) among NUM_CLIENTS requesters.
// Latency: grant registered one edge after request; ack_o follows mem_ack combinationally; 3 cycles/transaction.
// Backpressure: losing clients hold rq until acked; one forced mem_rq-low cycle separates RAM transactions.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int NUM_CLIENTS = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_CLIENTS-1:0]            rq_i,
    input  logic [NUM_CLIENTS-1:0]            wr_ni_i,
    input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] address_i,
    input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] dataW_i,
    output logic [NUM_CLIENTS-1:0]            ack_o,
    output logic [DATA_WIDTH-1:0]             dataR_o,
    output logic                              mem_rq,
    output logic                              mem_wr_ni,
    output logic [ADDR_WIDTH-1:0]             mem_address,
    output logic [DATA_WIDTH-1:0]             mem_dataW,
    input  logic                              mem_ack,
    input  logic [DATA_WIDTH-1:0]             mem_dataR
);

    localparam int IDX_W = clog2(NUM_CLIENTS);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] ptr_q,   ptr_d;

    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] ptr_after_grant;

    logic                  sel_rq;
    logic                  sel_wr_ni;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  busy;

    rr_picker #(
        .N     (NUM_CLIENTS),
        .IDX_W (IDX_W)
    ) u_rr_picker (
        .req_i   (rq_i),
        .ptr_i   (ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    assign busy = (state_q == BUSY);

    // Round-robin start moves one past the client just served, wrapping at NUM_CLIENTS.
    assign ptr_after_grant = (grant_q == IDX_W'(NUM_CLIENTS - 1)) ? '0 : (grant_q + IDX_W'(1));

    // Select the granted client's request fields.
    always_comb begin
        sel_rq    = 1'b0;
        sel_wr_ni = 1'b1;
        sel_addr  = '0;
        sel_data  = '0;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            if (IDX_W'(k) == grant_q) begin
                sel_rq    = rq_i[k];
                sel_wr_ni = wr_ni_i[k];
                sel_addr  = address_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data  = dataW_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // RAM request only while serving; outside BUSY force a read so no stray write can commit.
    assign mem_rq      = busy & sel_rq;
    assign mem_wr_ni   = busy ? sel_wr_ni : 1'b1;
    assign mem_address = sel_addr;
    assign mem_dataW   = sel_data;
    assign dataR_o     = mem_dataR;

    // Route the RAM acknowledge back to the granted client only.
    always_comb begin
        ack_o = '0;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            if (busy && (IDX_W'(k) == grant_q)) begin
                ack_o[k] = mem_ack;
            end
        end
    end

    // Next-state: GAP arbitrates like IDLE, which is what makes back-to-back service 3 cycles.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE, GAP: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    ptr_d   = ptr_after_grant;
                    state_d = GAP;
                end else if (!sel_rq) begin
                    // Client withdrew before ack: end the transaction without moving the fairness pointer.
                    state_d = GAP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, grant and round-robin pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule
